// File: rtl/spi_pkg.sv
// Shared types and widths for the SPI command sequencer and its command FIFO.
package spi_pkg;

    localparam int SPI_ADDR_W = 7;
    localparam int SPI_DATA_W = 8;

    // One queued host command, exactly as it will be presented to spi_master.
    typedef struct packed {
        logic                  rd_wr;
        logic [SPI_ADDR_W-1:0] addr;
        logic [SPI_DATA_W-1:0] wdata;
    } spi_cmd_t;

    // Sequencer states; the sequencer mirrors these encodings as localparams.
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FRAME,
        CAPTURE,
        RESP,
        GAP
    } seq_state_e;

endpackage

// File: rtl/spi_cmd_fifo.sv
// Small synchronous FIFO of SPI commands with an occupancy counter.
// The level counter, not the pointers, tells full from empty.
module spi_cmd_fifo
    import spi_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   mclk,
    input  logic                   reset,
    input  logic                   push,
    input  spi_cmd_t               push_data,
    output logic                   full,
    input  logic                   pop,
    output spi_cmd_t               head,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    spi_cmd_t         mem_q [DEPTH];
    spi_cmd_t         mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && (level_q != '0);
    assign head    = mem_q[rd_ptr_q];
    assign level   = level_q;

    // Next-state for storage, pointers and occupancy; pointers wrap naturally at DEPTH.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and level registers, cleared by the synchronous active-low reset.
    always_ff @(posedge mclk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Entry storage needs no reset: only entries below the level are ever read.
    always_ff @(posedge mclk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Command front-end for spi_master: queues host commands, issues each as one
// fixed-length frame, and returns read data through a valid/ready response port.
module spi_cmd_sequencer
    import spi_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int FRAME_CYCLES = 16,
    parameter int GAP_CYCLES   = 2
) (
    input  logic                        mclk,
    input  logic                        reset,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_rd_wr,
    input  logic [SPI_ADDR_W-1:0]       cmd_addr,
    input  logic [SPI_DATA_W-1:0]       cmd_wdata,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [SPI_ADDR_W-1:0]       rsp_addr,
    output logic [SPI_DATA_W-1:0]       rsp_rdata,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        start,
    output logic                        master_rd_wr,
    output logic [SPI_ADDR_W-1:0]       master_address,
    output logic [SPI_DATA_W-1:0]       master_out_data,
    input  logic [SPI_DATA_W-1:0]       master_in_data
);

    localparam logic [2:0] ST_IDLE    = 3'(IDLE);
    localparam logic [2:0] ST_LOAD    = 3'(LOAD);
    localparam logic [2:0] ST_FRAME   = 3'(FRAME);
    localparam logic [2:0] ST_CAPTURE = 3'(CAPTURE);
    localparam logic [2:0] ST_RESP    = 3'(RESP);
    localparam logic [2:0] ST_GAP     = 3'(GAP);

    // The LOAD cycle also has start low, so the GAP state itself lasts one
    // cycle less than the full idle gap between frames (but at least one).
    localparam int             CNT_W      = $clog2(FRAME_CYCLES);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0);

    logic [2:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  start_q, start_d;
    spi_cmd_t              mcmd_q, mcmd_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [SPI_ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
    logic [SPI_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    spi_cmd_t              push_cmd;
    spi_cmd_t              fifo_head;
    logic                  fifo_full;
    logic                  fifo_pop;

    assign push_cmd = {cmd_rd_wr, cmd_addr, cmd_wdata};
    assign fifo_pop = (state_q == ST_LOAD);

    spi_cmd_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .mclk     (mclk),
        .reset    (reset),
        .push     (cmd_valid),
        .push_data(push_cmd),
        .full     (fifo_full),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .level    (fifo_level)
    );

    assign cmd_ready       = !fifo_full;
    assign busy            = (state_q != ST_IDLE) || (fifo_level != '0);
    assign start           = start_q;
    assign master_rd_wr    = mcmd_q.rd_wr;
    assign master_address  = mcmd_q.addr;
    assign master_out_data = mcmd_q.wdata;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_addr        = rsp_addr_q;
    assign rsp_rdata       = rsp_rdata_q;

    // Sequencer FSM: the counter times the frame in FRAME and the idle spacing in GAP.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        start_d     = start_q;
        mcmd_d      = mcmd_q;
        rsp_valid_d = rsp_valid_q;
        rsp_addr_d  = rsp_addr_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (fifo_level != '0) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                mcmd_d  = fifo_head;
                start_d = 1'b1;
                cnt_d   = '0;
                state_d = ST_FRAME;
            end
            ST_FRAME: begin
                if (cnt_q == FRAME_LAST) begin
                    start_d = 1'b0;
                    cnt_d   = '0;
                    state_d = mcmd_q.rd_wr ? ST_CAPTURE : ST_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CAPTURE: begin
                rsp_rdata_d = master_in_data;
                rsp_addr_d  = mcmd_q.addr;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = (fifo_level != '0) ? ST_LOAD : ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // All sequencer state clears on reset, abandoning any frame in progress.
    always_ff @(posedge mclk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            start_q     <= 1'b0;
            mcmd_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            start_q     <= start_d;
            mcmd_q      <= mcmd_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Scoreboard bench for spi_cmd_sequencer: accepted commands are queued as
// expected frames/responses and checked when the sequencer issues them.
module tb_spi_cmd_sequencer;
    import spi_pkg::*;

    localparam int FIFO_DEPTH   = 4;
    localparam int FRAME_CYCLES = 16;
    localparam int GAP_CYCLES   = 2;

    logic       mclk = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_rd_wr = 1'b0;
    logic [6:0] cmd_addr = '0;
    logic [7:0] cmd_wdata = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [6:0] rsp_addr;
    logic [7:0] rsp_rdata;
    logic       busy;
    logic [2:0] fifo_level;
    logic       start;
    logic       master_rd_wr;
    logic [6:0] master_address;
    logic [7:0] master_out_data;
    logic [7:0] master_in_data;

    int assert_count = 0;
    int fail_count   = 0;

    spi_cmd_t    frame_q [$];
    logic [14:0] rsp_q   [$];

    int cyc = 0;
    int last_start_cyc = 0;
    int hs_cyc = 0;
    int frame_count = 0;
    int start_len = 0;
    bit prev_start = 0;
    bit prev_rsp_valid = 0;
    bit have_prev = 0;
    bit prev_was_read = 0;
    bit check_period = 0;
    bit arm_gap = 0;
    bit gap_pending = 0;

    spi_cmd_sequencer #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .FRAME_CYCLES(FRAME_CYCLES),
        .GAP_CYCLES  (GAP_CYCLES)
    ) dut (
        .mclk           (mclk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_rd_wr      (cmd_rd_wr),
        .cmd_addr       (cmd_addr),
        .cmd_wdata      (cmd_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_addr       (rsp_addr),
        .rsp_rdata      (rsp_rdata),
        .busy           (busy),
        .fifo_level     (fifo_level),
        .start          (start),
        .master_rd_wr   (master_rd_wr),
        .master_address (master_address),
        .master_out_data(master_out_data),
        .master_in_data (master_in_data)
    );

    always #5 mclk = ~mclk;

    // Slave model: the data returned for a read depends only on the address.
    function automatic logic [7:0] rdataFor(input logic [6:0] a);
        if (a == 7'h11) return 8'hC3;
        return {1'b1, a} ^ 8'h5A;
    endfunction

    assign master_in_data = rdataFor(master_address);

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Inputs change 2ns after the rising edge; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge mclk);
        #2;
    endtask

    task automatic applyStimulus(input logic rw, input logic [6:0] a, input logic [7:0] d);
        int wait_cycles = 0;
        cmd_valid = 1'b1;
        cmd_rd_wr = rw;
        cmd_addr  = a;
        cmd_wdata = d;
        while (!cmd_ready && wait_cycles < 100) begin
            tick();
            wait_cycles++;
        end
        if (cmd_ready) begin
            frame_q.push_back({rw, a, d});
            if (rw) rsp_q.push_back({a, rdataFor(a)});
        end else begin
            checkOutput("push_timeout", cmd_ready, 1);
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((busy || rsp_valid) && n < 500) begin
            tick();
            n++;
        end
        checkOutput("idle_timeout", busy, 0);
    endtask

    task automatic waitStart();
        int n = 0;
        while (!start && n < 100) begin
            tick();
            n++;
        end
        checkOutput("start_timeout", start, 1);
    endtask

    // Monitor: matches each frame and response against the scoreboard queues.
    always @(negedge mclk) begin
        cyc++;
        if (!reset) begin
            prev_start     = 0;
            prev_rsp_valid = 0;
            start_len      = 0;
            have_prev      = 0;
            gap_pending    = 0;
        end else begin
            if (start && !prev_start) begin
                spi_cmd_t exp_cmd;
                frame_count++;
                checkOutput("frame_expected", frame_q.size() != 0, 1);
                if (frame_q.size() != 0) begin
                    exp_cmd = frame_q.pop_front();
                    checkOutput("master_rd_wr", master_rd_wr, exp_cmd.rd_wr);
                    checkOutput("master_address", master_address, exp_cmd.addr);
                    if (!exp_cmd.rd_wr) checkOutput("master_out_data", master_out_data, exp_cmd.wdata);
                end
                if (check_period && have_prev && !prev_was_read)
                    checkOutput("start_period", cyc - last_start_cyc, FRAME_CYCLES + GAP_CYCLES);
                if (gap_pending) begin
                    checkOutput("gap_after_rsp", cyc - hs_cyc, GAP_CYCLES + 1);
                    gap_pending = 0;
                end
                last_start_cyc = cyc;
                have_prev      = 1;
                prev_was_read  = master_rd_wr;
                start_len      = 0;
            end
            if (start) start_len++;
            if (!start && prev_start) checkOutput("start_len", start_len, FRAME_CYCLES);
            if (rsp_valid && !prev_rsp_valid) begin
                checkOutput("rsp_expected", rsp_q.size() != 0, 1);
                // Counting the cycle in which start rose as cycle 1.
                checkOutput("rsp_latency", cyc - last_start_cyc + 1, FRAME_CYCLES + 2);
            end
            if (rsp_valid && rsp_ready) begin
                if (rsp_q.size() != 0) begin
                    logic [14:0] exp_rsp;
                    exp_rsp = rsp_q.pop_front();
                    checkOutput("rsp_addr", rsp_addr, exp_rsp[14:8]);
                    checkOutput("rsp_rdata", rsp_rdata, exp_rsp[7:0]);
                end
                if (arm_gap) begin
                    hs_cyc      = cyc;
                    gap_pending = 1;
                    arm_gap     = 0;
                end
            end
            prev_start     = start;
            prev_rsp_valid = rsp_valid;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int saved_frames;
        int wait_n;
        bit stall_bad;
        bit start_bad;

        // Reset state.
        tick(); tick(); tick();
        checkOutput("rst_start", start, 0);
        checkOutput("rst_master_rd_wr", master_rd_wr, 0);
        checkOutput("rst_master_address", master_address, 0);
        checkOutput("rst_master_out_data", master_out_data, 0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_rsp_addr", rsp_addr, 0);
        checkOutput("rst_rsp_rdata", rsp_rdata, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_fifo_level", fifo_level, 0);
        checkOutput("rst_cmd_ready", cmd_ready, 1);
        reset = 1'b1;
        tick();

        // Single write: start appears two edges after the push edge.
        $display("[TB] write 0x2A to 0x05");
        applyStimulus(1'b0, 7'h05, 8'h2A);
        checkOutput("lat_level_after_push", fifo_level, 1);
        checkOutput("lat_start_n", start, 0);
        tick();
        checkOutput("lat_start_n1", start, 0);
        tick();
        checkOutput("lat_start_n2", start, 1);
        checkOutput("lat_level_after_load", fifo_level, 0);
        waitIdle();

        // Single read with a known slave data byte.
        $display("[TB] read from 0x11");
        applyStimulus(1'b1, 7'h11, 8'h00);
        waitIdle();

        // Back-to-back writes filling the FIFO behind a running frame.
        $display("[TB] back-to-back writes");
        applyStimulus(1'b0, 7'h20, 8'h01);
        waitStart();
        check_period = 1;
        applyStimulus(1'b0, 7'h21, 8'h12);
        applyStimulus(1'b0, 7'h22, 8'h23);
        applyStimulus(1'b0, 7'h23, 8'h34);
        applyStimulus(1'b0, 7'h24, 8'h45);
        checkOutput("full_cmd_ready", cmd_ready, 0);
        checkOutput("full_level", fifo_level, FIFO_DEPTH);
        cmd_valid = 1'b1;
        cmd_rd_wr = 1'b0;
        cmd_addr  = 7'h25;
        cmd_wdata = 8'h56;
        wait_n = 0;
        while (fifo_level == 3'(FIFO_DEPTH) && wait_n < 100) begin
            tick();
            wait_n++;
        end
        checkOutput("pop_while_full_level", fifo_level, FIFO_DEPTH - 1);
        checkOutput("pop_while_full_ready", cmd_ready, 1);
        frame_q.push_back({1'b0, 7'h25, 8'h56});
        tick();
        cmd_valid = 1'b0;
        checkOutput("refill_level", fifo_level, FIFO_DEPTH);
        waitIdle();
        check_period = 0;

        // Read response stalled by the host while a write waits in the FIFO.
        $display("[TB] stalled read response");
        rsp_ready = 1'b0;
        applyStimulus(1'b1, 7'h33, 8'h00);
        applyStimulus(1'b0, 7'h44, 8'h99);
        wait_n = 0;
        while (!rsp_valid && wait_n < 100) begin
            tick();
            wait_n++;
        end
        checkOutput("stall_rsp_valid", rsp_valid, 1);
        stall_bad = 0;
        start_bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rsp_valid !== 1'b1 || rsp_addr !== 7'h33 || rsp_rdata !== rdataFor(7'h33)) stall_bad = 1;
            if (start !== 1'b0) start_bad = 1;
        end
        checkOutput("stall_rsp_stable", stall_bad, 0);
        checkOutput("stall_start_low", start_bad, 0);
        checkOutput("stall_level", fifo_level, 1);
        arm_gap   = 1;
        rsp_ready = 1'b1;
        tick();
        waitIdle();

        // Reset in the middle of a frame with two commands queued.
        $display("[TB] mid-frame reset");
        applyStimulus(1'b0, 7'h50, 8'hA0);
        applyStimulus(1'b0, 7'h51, 8'hA1);
        applyStimulus(1'b0, 7'h52, 8'hA2);
        waitStart();
        for (int i = 0; i < 7; i++) tick();
        checkOutput("pre_reset_level", fifo_level, 2);
        reset = 1'b0;
        tick();
        checkOutput("mid_rst_start", start, 0);
        checkOutput("mid_rst_level", fifo_level, 0);
        checkOutput("mid_rst_busy", busy, 0);
        frame_q.delete();
        rsp_q.delete();
        reset = 1'b1;
        saved_frames = frame_count;
        for (int i = 0; i < 40; i++) tick();
        checkOutput("no_frame_after_reset", frame_count, saved_frames);
        applyStimulus(1'b0, 7'h60, 8'h77);
        waitIdle();
        checkOutput("frame_after_new_push", frame_count, saved_frames + 1);

        tick();
        checkOutput("frames_drained", frame_q.size(), 0);
        checkOutput("rsps_drained", rsp_q.size(), 0);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
